mux_sel_arb: RTL and testbench
==============================

MUX_SEL_ARB -- requirements
Module: mux_sel_arb

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 4, the maximum consecutive grant cycles for one requester while the other is waiting (legal range 1..255).
REQ-002 The block SHALL have one parameter: CW, default 8, the width of the hold counter (2**CW > MAX_HOLD).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_a  input  1  request from source a; held high for as long as a needs the shared path.
REQ-006 req_b  input  1  request from source b; same rules as req_a.
REQ-007 gnt_a  output  1  source a owns the path.
REQ-008 gnt_b  output  1  source b owns the path.
REQ-009 sel  output  1  select for the downstream 2:1 mux; 1 routes input a, 0 routes input b.
REQ-010 busy  output  1  high while either grant is active.
REQ-011 hold_cnt  output  CW  cycles the current grant has been held, minus one; 0 when idle.

Function
REQ-012 The block SHALL implement three states: IDLE, GNT_A, GNT_B. All outputs SHALL be registered or decoded from registered state only. No combinational path from req_* to any output.
REQ-013 gnt_a SHALL be 1 only in GNT_A, and gnt_b only in GNT_B. busy SHALL be gnt_a|gnt_b. gnt_a and gnt_b SHALL never be high together.
REQ-014 sel SHALL be 1 in GNT_A and 0 in GNT_B. In IDLE, sel SHALL hold its last value.
REQ-015 A priority pointer prio (A or B) SHALL name the source that wins a tie. After any grant to a ends, prio SHALL become B. After any grant to b ends, prio SHALL become A.
REQ-016 IDLE: req_a only goes to GNT_A. req_b only goes to GNT_B. If both request, go to the state named by prio. If neither requests, stay in IDLE.
REQ-017 Latency: a request sampled at edge N in IDLE SHALL produce its grant visible after edge N (one-cycle req-to-gnt).
REQ-018 GNT_A behaviour SHALL be:
- req_a low: go to GNT_B if req_b is high, else go to IDLE.
- req_a high, req_b high, and hold_cnt == MAX_HOLD-1: go to GNT_B (forced rotation).
- Otherwise: stay in GNT_A.
REQ-019 GNT_B SHALL be symmetric to GNT_A with a and b swapped.
REQ-020 hold_cnt SHALL be cleared to 0 on entry to any grant state, including a direct A<->B handoff. While the grant is held it SHALL increment by 1 per cycle, saturating at MAX_HOLD-1. It SHALL be 0 in IDLE.
REQ-021 Direct handoff SHALL take zero idle cycles: gnt_a falls and gnt_b rises on the same edge.
REQ-022 MAX_HOLD=1 SHALL give strict alternation every cycle while both sources request.
REQ-023 A requester dropping req for one cycle SHALL lose its grant. Re-arbitration then follows REQ-016/018 with the updated prio.

Reset
REQ-024 While rst is high, the block SHALL be in IDLE with gnt_a=0, gnt_b=0, busy=0, sel=0, hold_cnt=0, prio=A. This SHALL take effect immediately, without waiting for clk.
REQ-025 Reset asserted mid-grant SHALL drop the grant asynchronously.
REQ-026 After rst deasserts, the first arbitration SHALL occur on the first rising clk edge at which rst is low.

Verification (MAX_HOLD=4)
REQ-027 Reset: rst=1 with req_a=req_b=1 for 3 cycles, then release -> outputs stay 0 during reset; gnt_a=1, sel=1 one edge after release.
REQ-028 Single requester: req_b=1 for 10 cycles, req_a=0 -> gnt_b held all 10 cycles with sel=0; hold_cnt runs 0,1,2,3,3,...; IDLE one edge after req_b falls, with sel still 0.
REQ-029 Contention: req_a=req_b=1 continuously from IDLE with prio=A -> grants alternate A×4, B×4, A×4; each handoff has zero gap and hold_cnt restarts at 0.
REQ-030 Early release: in GNT_A with req_b=1, drop req_a at hold_cnt=1 -> gnt_b=1 on the next edge; afterwards prio=A.
REQ-031 Async reset mid-grant: assert rst between clock edges during GNT_B -> gnt_b, busy and sel go to 0 before the next edge.
REQ-032 MAX_HOLD=1 build with both requesting -> gnt_a and gnt_b toggle every cycle; sel toggles 1,0,1,0.

Source files
------------

// File: rtl/mux_sel_arb_if.sv
// Request/grant bundle between two sources and the shared-path arbiter.
// The master side raises requests and observes grants; the slave side is the arbiter.
interface mux_sel_arb_if #(
    parameter int CW = 8
);
    logic          req_a;
    logic          req_b;
    logic          gnt_a;
    logic          gnt_b;
    logic          sel;
    logic          busy;
    logic [CW-1:0] hold_cnt;

    modport master (
        output req_a, req_b,
        input  gnt_a, gnt_b, sel, busy, hold_cnt
    );

    modport slave (
        input  req_a, req_b,
        output gnt_a, gnt_b, sel, busy, hold_cnt
    );
endinterface

// File: rtl/mux_sel_arb.sv
// Two-source arbiter for a shared 2:1 path. A tie goes to the source named by
// a rotating priority pointer, and a holder is forced to hand over after
// MAX_HOLD consecutive cycles while the other side waits. Every output comes
// from registered state, so there is no combinational path from req_* to the
// outputs.
module mux_sel_arb #(
    parameter int MAX_HOLD = 4,
    parameter int CW       = 8
) (
    input logic         clk,
    input logic         rst,
    mux_sel_arb_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_A = 2'b01;
    localparam logic [1:0] GNT_B = 2'b10;

    // Count value at which a contested grant must rotate.
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          prio_b;      // 1: b wins a tie, 0: a wins a tie
    logic          sel_q;
    logic [CW-1:0] cnt_q;

    // Next-state arbitration from the current owner, the requests and the hold count.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_a && bus.req_b) state_nxt = prio_b ? GNT_B : GNT_A;
                else if (bus.req_a)         state_nxt = GNT_A;
                else if (bus.req_b)         state_nxt = GNT_B;
                else                        state_nxt = IDLE;
            end
            GNT_A: begin
                if (!bus.req_a)                    state_nxt = bus.req_b ? GNT_B : IDLE;
                else if (bus.req_b && cnt_q == HOLD_LAST) state_nxt = GNT_B;
                else                               state_nxt = GNT_A;
            end
            GNT_B: begin
                if (!bus.req_b)                    state_nxt = bus.req_a ? GNT_A : IDLE;
                else if (bus.req_a && cnt_q == HOLD_LAST) state_nxt = GNT_A;
                else                               state_nxt = GNT_B;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Owner register; reset drops any grant without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Hold counter: restarts on every new grant, saturates while held, zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        cnt_q <= '0;
        else if (state_nxt == IDLE || state_nxt != state) cnt_q <= '0;
        else if (cnt_q != HOLD_LAST)                    cnt_q <= cnt_q + CW'(1);
    end

    // Priority pointer flips to the other source whenever a grant ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       prio_b <= 1'b0;
        else if (state == GNT_A && state_nxt != GNT_A) prio_b <= 1'b1;
        else if (state == GNT_B && state_nxt != GNT_B) prio_b <= 1'b0;
    end

    // Mux select follows the owner and keeps its last value through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     sel_q <= 1'b0;
        else if (state_nxt == GNT_A) sel_q <= 1'b1;
        else if (state_nxt == GNT_B) sel_q <= 1'b0;
    end

    assign bus.gnt_a    = (state == GNT_A);
    assign bus.gnt_b    = (state == GNT_B);
    assign bus.busy     = (state == GNT_A) || (state == GNT_B);
    assign bus.sel      = sel_q;
    assign bus.hold_cnt = cnt_q;

endmodule

// File: tb/tb_mux_sel_arb.sv
// Scoreboard bench for mux_sel_arb: a MAX_HOLD=4 build and a MAX_HOLD=1 build
// share the same request stimulus. A behavioural owner/run-length model
// predicts both, expectations are queued per edge, and a monitor compares them.
module tb_mux_sel_arb;

    typedef struct {
        int owner;   // 0 none, 1 a, 2 b
        int run;     // consecutive cycles the current owner has held the path
        bit prio_b;  // tie winner is b
        bit sel;
    } model_t;

    typedef struct packed {
        logic       ga;
        logic       gb;
        logic       sel;
        logic       busy;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        obs_t e4;
        obs_t e1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_a = 1'b0;
    logic req_b = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t   sb[$];
    model_t m4;
    model_t m1;

    mux_sel_arb_if #(.CW(8)) bus4 ();
    mux_sel_arb_if #(.CW(8)) bus1 ();

    assign bus4.req_a = req_a;
    assign bus4.req_b = req_b;
    assign bus1.req_a = req_a;
    assign bus1.req_b = req_b;

    mux_sel_arb #(.MAX_HOLD(4), .CW(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mux_sel_arb #(.MAX_HOLD(1), .CW(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.owner  = 0;
        m.run    = 0;
        m.prio_b = 1'b0;
        m.sel    = 1'b0;
        return m;
    endfunction

    // One arbitration edge from the rules: who owns the path after this edge.
    function automatic model_t step(model_t m, bit ra, bit rb, int maxh);
        model_t n;
        int     want;
        int     other_id;
        bit     mine;
        bit     other;
        n        = m;
        other_id = 3 - m.owner;
        mine     = (m.owner == 1) ? ra : rb;
        other    = (m.owner == 1) ? rb : ra;
        if (m.owner == 0) begin
            if (ra && rb)  want = m.prio_b ? 2 : 1;
            else if (ra)   want = 1;
            else if (rb)   want = 2;
            else           want = 0;
        end else if (!mine) begin
            want = other ? other_id : 0;
        end else if (other && m.run >= maxh) begin
            want = other_id;
        end else begin
            want = m.owner;
        end
        if (m.owner != 0 && want != m.owner) n.prio_b = (m.owner == 1);
        if (want == 0)            n.run = 0;
        else if (want == m.owner) n.run = m.run + 1;
        else                      n.run = 1;
        if (want == 1)      n.sel = 1'b1;
        else if (want == 2) n.sel = 1'b0;
        n.owner = want;
        return n;
    endfunction

    function automatic obs_t view(model_t m, int maxh);
        obs_t o;
        int   c;
        c      = (m.run == 0) ? 0 : ((m.run - 1 < maxh - 1) ? m.run - 1 : maxh - 1);
        o.ga   = (m.owner == 1);
        o.gb   = (m.owner == 2);
        o.sel  = m.sel;
        o.busy = (m.owner != 0);
        o.cnt  = 8'(c);
        return o;
    endfunction

    function automatic obs_t sample4();
        obs_t o;
        o.ga   = bus4.gnt_a;
        o.gb   = bus4.gnt_b;
        o.sel  = bus4.sel;
        o.busy = bus4.busy;
        o.cnt  = bus4.hold_cnt;
        return o;
    endfunction

    function automatic obs_t sample1();
        obs_t o;
        o.ga   = bus1.gnt_a;
        o.gb   = bus1.gnt_b;
        o.sel  = bus1.sel;
        o.busy = bus1.busy;
        o.cnt  = bus1.hold_cnt;
        return o;
    endfunction

    // Drive one cycle of stimulus and queue what both builds must show after the next edge.
    task automatic drive(input bit ra, input bit rb, input bit r);
        exp_t e;
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        rst   = r;
        if (r) begin
            m4 = model_reset();
            m1 = model_reset();
        end else begin
            m4 = step(m4, ra, rb, 4);
            m1 = step(m1, ra, rb, 1);
        end
        e.e4 = view(m4, 4);
        e.e1 = view(m1, 1);
        sb.push_back(e);
    endtask

    // Monitor: after each rising edge, compare the outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("mh4_cyc%0d", cyc), 32'(sample4()), 32'(e.e4));
                check($sformatf("mh1_cyc%0d", cyc), 32'(sample1()), 32'(e.e1));
            end
        end
    end

    initial begin
        m4 = model_reset();
        m1 = model_reset();

        // Reset takes effect before any clock edge.
        #1;
        rst   = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        #1;
        check("async_rst_idle", 32'(sample4()), 32'(view(model_reset(), 4)));

        // Reset held with both requesting, then release: a wins on the first edge.
        repeat (3) drive(1, 1, 1);
        drive(1, 1, 0);
        drive(0, 0, 0);
        repeat (2) drive(0, 0, 0);

        // Single requester b for ten cycles, then release.
        repeat (10) drive(0, 1, 0);
        repeat (3) drive(0, 0, 0);

        // Continuous contention from IDLE with prio back at a.
        repeat (14) drive(1, 1, 0);
        repeat (2) drive(0, 0, 0);

        // Early release of a at hold_cnt=1 while b waits.
        drive(1, 0, 0);
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);
        drive(1, 1, 0);
        repeat (2) drive(0, 0, 0);

        // One-cycle request drop loses the grant.
        repeat (2) drive(1, 0, 0);
        drive(0, 1, 0);
        drive(1, 1, 0);
        repeat (2) drive(0, 0, 0);

        // Asynchronous reset in the middle of a b grant.
        repeat (3) drive(0, 1, 0);
        @(posedge clk);
        #3;
        check("pre_rst_gnt_b", 32'(bus4.gnt_b), 32'(view(m4, 4).gb));
        rst = 1'b1;
        #1;
        check("midrst_gnt_b", 32'(bus4.gnt_b), 32'(0));
        check("midrst_busy", 32'(bus4.busy), 32'(0));
        check("midrst_sel", 32'(bus4.sel), 32'(0));
        check("midrst_cnt", 32'(bus4.hold_cnt), 32'(0));
        m4 = model_reset();
        m1 = model_reset();
        repeat (2) drive(0, 1, 1);
        repeat (3) drive(0, 1, 0);

        // Randomised traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 49) == 0);
        end
        drive(0, 0, 0);

        @(posedge clk);
        #3;
        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
